// File: rtl/race_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : race_cmp_pkg
//  Description : Shared types and helpers for the first-arrival comparator.
//                - race_state_t   : comparator FSM state encoding
//                - prio_lowest    : index of the lowest set bit of a vector
//                - more_than_one  : true when two or more bits are set
//                Vectors are passed zero-extended to c_VEC_W bits, which
//                covers the largest supported channel count.
//  Revision    : 1.0  initial release
// ============================================================================
package race_cmp_pkg;

    localparam int c_VEC_W = 16;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        LOCKED   = 2'd2
    } race_state_t;

    // Scan from the top down so the last hit written is the lowest index.
    function automatic logic [3:0] prio_lowest(input logic [c_VEC_W-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = c_VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if a second bit was set.
    function automatic logic more_than_one(input logic [c_VEC_W-1:0] vec);
        return (vec & (vec - 16'd1)) != 16'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Two-flop synchroniser followed by a stable-level debouncer
//                for one raw channel. A new level on the synchronised input
//                is accepted only after DB_CYCLES consecutive cycles.
//  Ports       : clock    - system clock, rising edge
//                resetBTN - synchronous active-low reset
//                raw      - asynchronous raw input
//                s2       - synchronised level (second flop)
//                db       - debounced level
//  Revision    : 1.0  initial release
// ============================================================================
module input_debouncer #(
    parameter int DB_CYCLES = 4
) (
    input  logic clock,
    input  logic resetBTN,
    input  logic raw,
    output logic s2,
    output logic db
);

    localparam int                 c_CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic               r_s1;
    logic               r_s2;
    logic               r_db;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (!resetBTN) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                // Any return to the accepted level restarts the window.
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign s2 = r_s2;
    assign db = r_db;

endmodule
`default_nettype wire

// File: rtl/race_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : race_comparator
//  Description : N-channel first-arrival comparator. Each raw input is
//                synchronised and debounced; the first debounced rising edge
//                while ARMED is latched as the winner together with a tie
//                flag and the mask of all channels that rose in that cycle.
//  Ports       : clock    - system clock, rising edge
//                resetBTN - synchronous active-low reset
//                in_raw   - asynchronous raw channel inputs, active-high
//                oc       - result valid
//                winner   - lowest index that rose in the winning cycle
//                tie      - more than one channel rose in the winning cycle
//                hit_mask - channels that rose in the winning cycle
//                armed    - comparator is waiting for a first arrival
//  Revision    : 1.0  initial release
// ============================================================================
module race_comparator
    import race_cmp_pkg::*;
#(
    parameter  int N_CH       = 2,
    parameter  int DB_CYCLES  = 4,
    parameter  int AUTO_REARM = 0,
    localparam int IDX_W      = $clog2(N_CH)
) (
    input  logic             clock,
    input  logic             resetBTN,
    input  logic [N_CH-1:0]  in_raw,
    output logic             oc,
    output logic [IDX_W-1:0] winner,
    output logic             tie,
    output logic [N_CH-1:0]  hit_mask,
    output logic             armed
);

    localparam int               c_Q_W    = $clog2(DB_CYCLES + 3);
    localparam logic [c_Q_W-1:0] c_Q_LAST = c_Q_W'(DB_CYCLES + 1);

    logic [N_CH-1:0]  w_s2;
    logic [N_CH-1:0]  w_db;
    logic [N_CH-1:0]  w_rise;
    logic             w_all_low;

    logic [N_CH-1:0]  r_db_d;
    race_state_t      r_state;
    race_state_t      w_state_nxt;
    logic [c_Q_W-1:0] r_quiet;
    logic [c_Q_W-1:0] w_quiet_nxt;
    logic             r_oc;
    logic             w_oc_nxt;
    logic [IDX_W-1:0] r_winner;
    logic [IDX_W-1:0] w_winner_nxt;
    logic             r_tie;
    logic             w_tie_nxt;
    logic [N_CH-1:0]  r_mask;
    logic [N_CH-1:0]  w_mask_nxt;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        input_debouncer #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debouncer (
            .clock    (clock),
            .resetBTN (resetBTN),
            .raw      (in_raw[gi]),
            .s2       (w_s2[gi]),
            .db       (w_db[gi])
        );
    end

    assign w_rise    = w_db & ~r_db_d;
    // Both the synchronised and debounced levels must be low, so a channel
    // still bouncing or held high keeps the comparator from arming.
    assign w_all_low = ~|{w_s2, w_db};

    always_comb begin
        w_state_nxt  = r_state;
        w_quiet_nxt  = '0;
        w_oc_nxt     = r_oc;
        w_winner_nxt = r_winner;
        w_tie_nxt    = r_tie;
        w_mask_nxt   = r_mask;
        case (r_state)
            WAIT_LOW: begin
                if (w_all_low) begin
                    if (r_quiet == c_Q_LAST) begin
                        w_state_nxt = ARMED;
                    end else begin
                        w_quiet_nxt = r_quiet + 1'b1;
                    end
                end
            end
            ARMED: begin
                if (|w_rise) begin
                    w_state_nxt  = LOCKED;
                    w_oc_nxt     = 1'b1;
                    w_mask_nxt   = w_rise;
                    w_winner_nxt = IDX_W'(prio_lowest(c_VEC_W'(w_rise)));
                    w_tie_nxt    = more_than_one(c_VEC_W'(w_rise));
                end
            end
            LOCKED: begin
                if ((AUTO_REARM != 0) && !(|w_db)) begin
                    w_state_nxt  = WAIT_LOW;
                    w_oc_nxt     = 1'b0;
                    w_winner_nxt = '0;
                    w_tie_nxt    = 1'b0;
                    w_mask_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOW;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetBTN) begin
            r_db_d   <= '0;
            r_state  <= WAIT_LOW;
            r_quiet  <= '0;
            r_oc     <= 1'b0;
            r_winner <= '0;
            r_tie    <= 1'b0;
            r_mask   <= '0;
        end else begin
            r_db_d   <= w_db;
            r_state  <= w_state_nxt;
            r_quiet  <= w_quiet_nxt;
            r_oc     <= w_oc_nxt;
            r_winner <= w_winner_nxt;
            r_tie    <= w_tie_nxt;
            r_mask   <= w_mask_nxt;
        end
    end

    assign oc       = r_oc;
    assign winner   = r_winner;
    assign tie      = r_tie;
    assign hit_mask = r_mask;
    assign armed    = (r_state == ARMED);

endmodule
`default_nettype wire

// File: tb/tb_race_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_race_comparator
//  Description : Scoreboard bench for race_comparator. Two instances share
//                the same inputs: dut_a rearms automatically, dut_l latches
//                until reset. Each race round describes every channel as
//                idle, a short glitch or a held level with an arrival offset;
//                the expected win, clear and rearm events for dut_a are
//                derived from those arrival times and queued, and a monitor
//                pops them as the outputs change.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_race_comparator;

    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int RLEN = 40;

    typedef struct {
        int         cyc;
        logic [1:0] win;
        logic       tie;
        logic [N-1:0] mask;
    } exp_t;

    logic         clock = 1'b0;
    logic         resetBTN;
    logic [N-1:0] in_raw;

    logic         oc_a, tie_a, armed_a;
    logic [1:0]   win_a;
    logic [N-1:0] mask_a;
    logic         oc_l, tie_l, armed_l;
    logic [1:0]   win_l;
    logic [N-1:0] mask_l;

    race_comparator #(.N_CH(N), .DB_CYCLES(DB), .AUTO_REARM(1)) dut_a (
        .clock(clock), .resetBTN(resetBTN), .in_raw(in_raw), .oc(oc_a),
        .winner(win_a), .tie(tie_a), .hit_mask(mask_a), .armed(armed_a)
    );

    race_comparator #(.N_CH(N), .DB_CYCLES(DB), .AUTO_REARM(0)) dut_l (
        .clock(clock), .resetBTN(resetBTN), .in_raw(in_raw), .oc(oc_l),
        .winner(win_l), .tie(tie_l), .hit_mask(mask_l), .armed(armed_l)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   clr_q[$];
    int   arm_q[$];

    int   offs[N];
    int   lens[N];
    logic won_l = 1'b0;
    logic [1:0]   first_win;
    logic         first_tie;
    logic [N-1:0] first_mask;

    logic mon_en = 1'b0;
    logic p_oc   = 1'b0;
    logic p_arm  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares dut_a output transitions against the queued events.
    always @(negedge clock) begin
        if (mon_en) begin
            if (oc_a && !p_oc) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_win", 32'd1, 32'd0);
                end else begin
                    check("win_latency", cyc, exp_q[0].cyc);
                    check("win_result", {win_a, tie_a, mask_a, armed_a},
                          {exp_q[0].win, exp_q[0].tie, exp_q[0].mask, 1'b0});
                    void'(exp_q.pop_front());
                end
            end
            if (!oc_a && p_oc) begin
                if (clr_q.size() == 0) begin
                    check("unexpected_clear", 32'd1, 32'd0);
                end else begin
                    check("clear_time", cyc, clr_q[0]);
                    check("clear_value", {win_a, tie_a, mask_a}, 32'd0);
                    void'(clr_q.pop_front());
                end
            end
            if (armed_a && !p_arm) begin
                if (arm_q.size() == 0) begin
                    check("unexpected_arm", 32'd1, 32'd0);
                end else begin
                    check("arm_time", cyc, arm_q[0]);
                    void'(arm_q.pop_front());
                end
            end
        end
        p_oc  <= oc_a;
        p_arm <= armed_a;
    end

    task automatic wait_armed();
        for (int i = 0; i < 100 && !armed_a; i++) @(negedge clock);
        if (!armed_a) check("arm_timeout", 32'd0, 32'd1);
    endtask

    // One race: real channels rise at offs[i] and hold until HOLD, glitch
    // channels pulse for lens[i] (< DB) cycles starting at offs[i].
    task automatic run_round(input logic [N-1:0] real_m, input logic [N-1:0] gl_m);
        int           t0;
        int           min_off;
        logic [N-1:0] m;
        exp_t         e;
        wait_armed();
        t0      = cyc;
        min_off = 1000;
        for (int i = 0; i < N; i++)
            if (real_m[i] && offs[i] < min_off) min_off = offs[i];
        if (real_m != '0) begin
            m = '0;
            for (int i = 0; i < N; i++)
                if (real_m[i] && offs[i] == min_off) m[i] = 1'b1;
            e.win = 2'd0;
            for (int i = N - 1; i >= 0; i--)
                if (m[i]) e.win = 2'(i);
            e.tie  = ($countones(m) > 1);
            e.mask = m;
            // Arrival sampled one edge after drive, then sync + debounce + latch.
            e.cyc  = t0 + min_off + DB + 3;
            exp_q.push_back(e);
            clr_q.push_back(t0 + HOLD + DB + 3);
            arm_q.push_back(t0 + HOLD + DB + 3 + DB + 2);
            if (!won_l) begin
                won_l      = 1'b1;
                first_win  = e.win;
                first_tie  = e.tie;
                first_mask = e.mask;
            end
        end
        for (int c = 0; c < RLEN; c++) begin
            for (int i = 0; i < N; i++)
                in_raw[i] = (real_m[i] && c >= offs[i] && c < HOLD) ||
                            (gl_m[i] && c >= offs[i] && c < offs[i] + lens[i]);
            @(negedge clock);
        end
        check("a_idle_at_end", {oc_a, armed_a}, 32'b01);
        if (won_l)
            check("l_latched", {oc_l, win_l, tie_l, mask_l, armed_l},
                  {1'b1, first_win, first_tie, first_mask, 1'b0});
        else
            check("l_idle_at_end", {oc_l, armed_l}, 32'b01);
    endtask

    task automatic clear_offs();
        for (int i = 0; i < N; i++) begin
            offs[i] = 0;
            lens[i] = 1;
        end
    endtask

    initial begin
        int   d;
        logic saw_oc;
        logic [N-1:0] rm, gm;
        int   role;

        resetBTN = 1'b0;
        in_raw   = '0;
        repeat (3) @(negedge clock);
        check("reset_a", {oc_a, win_a, tie_a, mask_a, armed_a}, 32'd0);
        check("reset_l", {oc_l, win_l, tie_l, mask_l, armed_l}, 32'd0);
        mon_en   = 1'b1;
        resetBTN = 1'b1;
        arm_q.push_back(cyc + DB + 2);

        // Single channel, tie with a later arrival, glitch then level, ch3.
        clear_offs();                 run_round(4'b0100, 4'b0000);
        clear_offs(); offs[0] = 3;    run_round(4'b1011, 4'b0000);
        clear_offs(); lens[0] = DB-1; run_round(4'b0000, 4'b0001);
        clear_offs();                 run_round(4'b0001, 4'b0000);
        clear_offs();                 run_round(4'b1000, 4'b0000);
        clear_offs(); offs[1] = 1;    run_round(4'b0110, 4'b0000);

        for (int r = 0; r < 24; r++) begin
            rm = '0;
            gm = '0;
            for (int i = 0; i < N; i++) begin
                role    = $urandom_range(0, 2);
                offs[i] = $urandom_range(0, 4);
                lens[i] = $urandom_range(1, DB - 1);
                if (role == 1) gm[i] = 1'b1;
                if (role == 2) rm[i] = 1'b1;
            end
            run_round(rm, gm);
        end

        check("queues_drained", exp_q.size() + clr_q.size() + arm_q.size(), 32'd0);
        mon_en = 1'b0;

        // Reset while LOCKED, with in_raw[2] still high through release.
        wait_armed();
        in_raw = 4'b0100;
        for (int i = 0; i < 20 && !oc_a; i++) @(negedge clock);
        check("pre_reset_win", {oc_a, win_a}, 32'b110);
        resetBTN = 1'b0;
        @(negedge clock);
        check("mid_reset_a", {oc_a, win_a, tie_a, mask_a, armed_a}, 32'd0);
        check("mid_reset_l", {oc_l, win_l, tie_l, mask_l, armed_l}, 32'd0);
        resetBTN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("held_high_a", {armed_a, oc_a}, 32'd0);
            check("held_high_l", {armed_l, oc_l}, 32'd0);
        end
        d      = cyc;
        in_raw = '0;
        saw_oc = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (oc_a || oc_l) saw_oc = 1'b1;
            if (armed_a) break;
        end
        check("rearm_after_drop", cyc, d + 2 * DB + 4);
        check("rearm_state", {armed_a, armed_l, saw_oc}, 32'b110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
